// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and word-level helpers.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_DONE   = 2'd2
    } sha_state_t;

    localparam logic [0:63][31:0] SHA_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // A 32-byte key fills exactly one block: 0x80 marker, zeros, 256-bit length.
    localparam logic [255:0] SHA_KEY_PAD = {1'b1, 191'b0, 64'd256};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] s;
        for (int i = 0; i < 8; i++) begin
            s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return s;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the packed a..h state.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_k,
    input  logic [31:0]  i_w,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_bsig0, w_bsig1, w_ch, w_maj, w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_bsig1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
    assign w_bsig0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
    assign w_ch    = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj   = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1    = w_h + w_bsig1 + w_ch + i_k + i_w;
    assign w_t2    = w_bsig0 + w_maj;

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_top.sv
// Single-block SHA-256 engine with chaining and key-hash mode.
// Define SHA_PUFOUT_EN to keep the last key-mode digest on pufout.
module sha256_top
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         next,
    input  logic         sel,
    input  logic [511:0] block,
    input  logic [255:0] signing_key,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic [255:0] pufout
);

    sha_state_t   r_state, w_state_nxt;
    logic [5:0]   r_t;
    logic [511:0] r_w;
    logic [255:0] r_wv, r_chain, r_digest;
    logic         r_valid;
    logic         w_accept, w_chain_sel;
    logic [511:0] w_msg;
    logic [255:0] w_chain0, w_round_out;
    logic [31:0]  w_wnew;

    assign w_accept    = (r_state == ST_IDLE) && (init || next);
    assign w_chain_sel = next && !init && r_valid;
    assign w_msg       = sel ? block : {signing_key, SHA_KEY_PAD};
    assign w_chain0    = w_chain_sel ? r_digest : SHA_IV;

    // Window holds W[t..t+15], W[t] in the top word; append W[t+16].
    assign w_wnew = ssig1(r_w[63:32]) + r_w[223:192] + ssig0(r_w[479:448]) + r_w[511:480];

    sha256_round u_round (
        .i_state (r_wv),
        .i_k     (SHA_K[r_t]),
        .i_w     (r_w[511:480]),
        .o_state (w_round_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_ROUNDS;
            ST_ROUNDS: if (r_t == 6'd63) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_t      <= '0;
            r_valid  <= 1'b0;
            r_digest <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_t     <= '0;
                r_valid <= 1'b0;
            end else if (r_state == ST_ROUNDS) begin
                r_t <= r_t + 6'd1;
            end
            if (r_state == ST_DONE) begin
                r_digest <= add8(r_chain, r_wv);
                r_valid  <= 1'b1;
            end
        end
    end

    // Datapath registers carry no reset; they are always loaded at acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_w     <= w_msg;
            r_chain <= w_chain0;
            r_wv    <= w_chain0;
        end else if (r_state == ST_ROUNDS) begin
            r_w  <= {r_w[479:0], w_wnew};
            r_wv <= w_round_out;
        end
    end

`ifdef SHA_PUFOUT_EN
    logic         r_sel;
    logic [255:0] r_pufout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel    <= 1'b0;
            r_pufout <= '0;
        end else begin
            if (w_accept) r_sel <= sel;
            if (r_state == ST_DONE && !r_sel) r_pufout <= add8(r_chain, r_wv);
        end
    end

    assign pufout = r_pufout;
`else
    assign pufout = '0;
`endif

    assign ready        = (r_state == ST_IDLE);
    assign digest       = r_digest;
    assign digest_valid = r_valid;

endmodule

// File: tb/tb_sha256_top.sv
// Directed testbench for sha256_top: known-answer digests, key mode, protocol and reset.
module tb_sha256_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init, next, sel;
    logic [511:0] block;
    logic [255:0] signing_key;
    logic         ready, digest_valid;
    logic [255:0] digest, pufout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cmd_cyc  = 0;

    localparam logic [31:0] RK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'b0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'b0, 32'h00000018};
    localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B    = {480'b0, 32'h000001c0};
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] KEY     = 256'h3F7A_91C4_5E20_B8D3_6A1F_C047_E59B_2D86_11F3_A4C8_7B02_DE69_5C3A_8F17_E4B0_596D;

    sha256_top dut (
        .clk          (clk),
        .rst          (rst_n),
        .init         (init),
        .next         (next),
        .sel          (sel),
        .block        (block),
        .signing_key  (signing_key),
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid),
        .pufout       (pufout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression with a fully expanded 64-entry schedule.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + RK[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    task automatic issue(input logic i_init, input logic i_next, input logic i_sel,
                         input logic [511:0] i_blk, input logic [255:0] i_key);
        @(negedge clk);
        init = i_init; next = i_next; sel = i_sel; block = i_blk; signing_key = i_key;
        @(posedge clk);
        #1;
        cmd_cyc = cyc;
        init = 1'b0; next = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = cyc - cmd_cyc;
                break;
            end
        end
        check({tag, "_latency"}, lat, 65);
        check({tag, "_valid"}, digest_valid, 1'b1);
    endtask

    task automatic hash(input string tag, input logic i_init, input logic i_next, input logic i_sel,
                        input logic [511:0] i_blk, input logic [255:0] i_key);
        issue(i_init, i_next, i_sel, i_blk, i_key);
        check({tag, "_busy"}, ready, 1'b0);
        wait_ready(tag);
    endtask

    initial begin
        logic [255:0] key_dig, exp_puf;
        rst_n = 1'b0; init = 1'b0; next = 1'b0; sel = 1'b1; block = '0; signing_key = '0;
        #12;
        check("rst_ready", ready, 1'b1);
        check("rst_valid", digest_valid, 1'b0);
        check("rst_digest", digest, '0);
        check("rst_pufout", pufout, '0);
        @(negedge clk) rst_n = 1'b1;

        // next with no valid digest starts from the IV
        hash("next_as_init", 1'b0, 1'b1, 1'b1, BLK_ABC, '0);
        check("next_as_init_digest", digest, D_ABC);

        hash("empty", 1'b1, 1'b0, 1'b1, BLK_EMPTY, '0);
        check("empty_digest", digest, D_EMPTY);

        hash("abc", 1'b1, 1'b0, 1'b1, BLK_ABC, '0);
        check("abc_digest", digest, D_ABC);

        hash("two_a", 1'b1, 1'b0, 1'b1, BLK_2A, '0);
        check("two_a_digest", digest, ref_compress(IV, BLK_2A));
        hash("two_b", 1'b0, 1'b1, 1'b1, BLK_2B, '0);
        check("two_b_digest", digest, D_TWO);

        key_dig = ref_compress(IV, {KEY, 32'h80000000, 160'b0, 64'd256});
`ifdef SHA_PUFOUT_EN
        exp_puf = key_dig;
`else
        exp_puf = '0;
`endif
        hash("key", 1'b1, 1'b0, 1'b0, BLK_EMPTY, KEY);
        check("key_digest", digest, key_dig);
        check("key_pufout", pufout, exp_puf);
        hash("after_key", 1'b1, 1'b0, 1'b1, BLK_ABC, ~KEY);
        check("after_key_digest", digest, D_ABC);
        check("after_key_pufout", pufout, exp_puf);

        // init and next together: must restart from IV, not chain from abc
        hash("init_next", 1'b1, 1'b1, 1'b1, BLK_EMPTY, '0);
        check("init_next_digest", digest, D_EMPTY);

        // command and block change while busy are both ignored
        issue(1'b1, 1'b0, 1'b1, BLK_ABC, '0);
        repeat (10) @(negedge clk);
        block = BLK_EMPTY; sel = 1'b0; init = 1'b1;
        @(negedge clk);
        check("busy_ready", ready, 1'b0);
        init = 1'b0; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_ready("busy");
        check("busy_digest", digest, D_ABC);
        check("busy_pufout", pufout, exp_puf);

        // asynchronous reset in the middle of a hash
        issue(1'b1, 1'b0, 1'b1, BLK_2A, '0);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1'b1);
        check("midrst_valid", digest_valid, 1'b0);
        check("midrst_digest", digest, '0);
        check("midrst_pufout", pufout, '0);
        @(negedge clk) rst_n = 1'b1;
        hash("post_rst", 1'b1, 1'b0, 1'b1, BLK_EMPTY, '0);
        check("post_rst_digest", digest, D_EMPTY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
